// File: rtl/kianv_router_pkg.sv
// rtl/kianv_router_pkg.sv - shared types and helpers for the kianv memory router
package kianv_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'h0000_0000;

  // A single-slave router still needs a 1-bit select register.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kianv_router_decode.sv
// rtl/kianv_router_decode.sv - base/mask priority decoder, lowest index wins
module kianv_router_decode
  import kianv_router_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = sel_w(NUM_SLAVES)
) (
  input  logic [31:0]              i_addr,
  input  logic [NUM_SLAVES*32-1:0] i_bases,
  input  logic [NUM_SLAVES*32-1:0] i_masks,
  output logic                     o_hit,
  output logic [SEL_W-1:0]         o_sel
);

  // Scan from the top down so the lowest-index match is the last write.
  always_comb begin
    o_hit = 1'b0;
    o_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr & i_masks[32*i +: 32]) == i_bases[32*i +: 32]) begin
        o_hit = 1'b1;
        o_sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/kianv_mem_router.sv
// rtl/kianv_mem_router.sv - kianv valid/ready master to NUM_SLAVES slaves with
// registered select, response timeout and sticky error capture
module kianv_mem_router
  import kianv_router_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {32'h2000_0000, 32'h1000_0000,
                                                        32'h3000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {32'hFF00_0000, 32'hFFFF_0000,
                                                        32'hFFFF_0000, 32'hFFFF_8000},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     bus_error,
  output logic                     err_flag,
  output logic [31:0]              err_addr,
  input  logic                     err_clear
);

  localparam int          SEL_W    = sel_w(NUM_SLAVES);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [SEL_W-1:0]  r_sel;
  logic [15:0]       r_cnt;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              r_err_flag;
  logic [31:0]       r_err_addr;
  logic              w_dec_hit;
  logic [SEL_W-1:0]  w_dec_sel;
  logic              w_sel_ready;
  logic [31:0]       w_sel_rdata;
  logic              w_timeout;
  logic              w_err_now;
  logic [31:0]       w_err_addr;

  kianv_router_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_decode (
    .i_addr  (mem_addr),
    .i_bases (SLAVE_BASE),
    .i_masks (SLAVE_MASK),
    .o_hit   (w_dec_hit),
    .o_sel   (w_dec_sel)
  );

  // Only the selected slave is looked at; the others' ready is ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    s_valid     = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_sel_ready = s_ready[i];
        w_sel_rdata = s_rdata[32*i +: 32];
        s_valid[i]  = (r_state == ST_WAIT);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_err_now  = 1'b0;
    w_timeout  = (r_cnt == CNT_LAST);
    w_err_addr = (r_state == ST_IDLE) ? mem_addr : r_addr;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid) begin
          if (w_dec_hit) begin
            w_next = ST_WAIT;
          end else begin
            w_next    = ST_DONE;
            w_err_now = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (w_sel_ready) begin
          w_next = ST_DONE;
        end else if (w_timeout) begin
          w_next    = ST_DONE;
          w_err_now = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel      <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_err_flag <= 1'b0;
      r_err_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_valid) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_sel   <= w_dec_sel;
            r_cnt   <= '0;
            r_err   <= ~w_dec_hit;
            if (!w_dec_hit) r_rdata <= ERR_RDATA;
          end
        end
        ST_WAIT: begin
          if (w_sel_ready) begin
            r_rdata <= w_sel_rdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= ERR_RDATA;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase

      // A new error beats a same-cycle clear and records its own address.
      if (w_err_now) begin
        r_err_flag <= 1'b1;
        if (!r_err_flag || err_clear) r_err_addr <= w_err_addr;
      end else if (err_clear) begin
        r_err_flag <= 1'b0;
        r_err_addr <= '0;
      end
    end
  end

  assign mem_ready = (r_state == ST_DONE);
  assign bus_error = mem_ready & r_err;
  assign mem_rdata = r_rdata;
  assign s_addr    = r_addr;
  assign s_wdata   = r_wdata;
  assign s_wstrb   = r_wstrb;
  assign err_flag  = r_err_flag;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_kianv_mem_router.sv
// tb/tb_kianv_mem_router.sv - scoreboard bench for kianv_mem_router
module tb_kianv_mem_router;

  localparam int              NS   = 4;
  localparam int              TO   = 8;
  localparam logic [31:0]     ERRD = 32'hDEAD_BEEF;
  localparam logic [NS*32-1:0] BASES = {32'h2000_0000, 32'h0000_0000, 32'h3000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_8000};

  logic [31:0] ref_base [NS] = '{32'h0000_0000, 32'h3000_0000, 32'h0000_0000, 32'h2000_0000};
  logic [31:0] ref_mask [NS] = '{32'hFFFF_8000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000};

  logic           clk = 1'b0;
  logic           reset;
  logic           mem_valid;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic [3:0]     mem_wstrb;
  logic           mem_ready;
  logic [31:0]    mem_rdata;
  logic [NS-1:0]  s_valid;
  logic [31:0]    s_addr;
  logic [31:0]    s_wdata;
  logic [3:0]     s_wstrb;
  logic [NS-1:0]  s_ready;
  logic [NS*32-1:0] s_rdata;
  logic           bus_error;
  logic           err_flag;
  logic [31:0]    err_addr;
  logic           err_clear;

  kianv_mem_router #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     (BASES),
    .SLAVE_MASK     (MASKS),
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (ERRD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .s_valid   (s_valid),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .bus_error (bus_error),
    .err_flag  (err_flag),
    .err_addr  (err_addr),
    .err_clear (err_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          sel;
    int          issue;
    int          nvalid;
    int          lat_cyc;
    logic        err;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        flag;
    logic [31:0] eaddr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rmem [logic [63:0]];
  logic [31:0] smem [logic [63:0]];
  logic        m_flag = 1'b0;
  logic [31:0] m_eaddr = '0;
  int          n_total = 0;
  int          n_pass = 0;
  int          cur_lat = 0;
  int          sv_cnt = 0;
  bit          in_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] dflt(input int s, input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ (32'(s) << 28);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] st);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if ((a & ref_mask[i]) == ref_base[i]) return i;
    return -1;
  endfunction

  // Slave models: selected slave answers after cur_lat cycles; idle slaves toggle noise.
  initial begin
    int          scnt [NS];
    logic [63:0] k;
    s_ready = '0;
    s_rdata = '0;
    for (int i = 0; i < NS; i++) scnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (s_valid[i]) begin
          k = {32'(i), s_addr};
          s_rdata[32*i +: 32] = smem.exists(k) ? smem[k] : dflt(i, s_addr);
          s_ready[i] = (scnt[i] == cur_lat);
          if (s_ready[i] && s_wstrb != 4'd0) smem[k] = merge(s_rdata[32*i +: 32], s_wdata, s_wstrb);
          scnt[i]++;
        end else begin
          scnt[i] = 0;
          s_ready[i] = 1'($urandom);
          s_rdata[32*i +: 32] = $urandom;
        end
      end
    end
  end

  // Monitor: checks slave-side request while in flight and the response on mem_ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (s_valid != '0) begin
          if (exp_q.size() == 0) begin
            check("spurious_s_valid", 32'(s_valid), 32'd0);
          end else begin
            e = exp_q[0];
            check("s_valid_onehot", 32'(s_valid), (e.sel >= 0) ? (32'd1 << e.sel) : 32'd0);
            check("s_addr", s_addr, e.addr);
            check("s_wdata", s_wdata, e.wdata);
            check("s_wstrb", 32'(s_wstrb), 32'(e.wstrb));
            sv_cnt++;
          end
        end
        if (mem_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_mem_ready", 32'(mem_ready), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("latency", 32'(cyc - e.issue), 32'(e.lat_cyc));
            check("s_valid_cycles", 32'(sv_cnt), 32'(e.nvalid));
            check("bus_error", 32'(bus_error), 32'(e.err));
            if (e.chk_rdata) check("mem_rdata", mem_rdata, e.rdata);
            check("err_flag", 32'(err_flag), 32'(e.flag));
            check("err_addr", err_addr, e.eaddr);
            sv_cnt = 0;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    in_done = 1'b0;
  endtask

  // Called at a negedge; a call straight after a completion starts in the DONE cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input int lat, input bit clr);
    exp_t        e;
    int          s;
    logic [63:0] k;
    logic [31:0] old;
    bit          done;
    s = ref_decode(a);
    e.addr = a; e.wdata = wd; e.wstrb = ws; e.sel = s;
    e.issue = cyc + (in_done ? 1 : 0);
    if (s < 0) begin
      e.err = 1'b1; e.nvalid = 0; e.lat_cyc = 1;
    end else if (lat < TO) begin
      e.err = 1'b0; e.nvalid = lat + 1; e.lat_cyc = lat + 2;
    end else begin
      e.err = 1'b1; e.nvalid = TO; e.lat_cyc = TO + 1;
    end
    e.chk_rdata = e.err || (ws == 4'd0);
    e.rdata = ERRD;
    if (!e.err) begin
      k = {32'(s), a};
      old = rmem.exists(k) ? rmem[k] : dflt(s, a);
      e.rdata = old;
      if (ws != 4'd0) rmem[k] = merge(old, wd, ws);
    end
    if (e.err) begin
      if (!m_flag || clr) m_eaddr = a;
      m_flag = 1'b1;
    end else if (clr) begin
      m_flag = 1'b0;
      m_eaddr = '0;
    end
    e.flag = m_flag;
    e.eaddr = m_eaddr;
    exp_q.push_back(e);
    cur_lat = lat;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws; err_clear = clr;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      err_clear = 1'b0;
      if (mem_ready) done = 1'b1;
    end
    mem_valid = 1'b0;
    in_done = 1'b1;
    check("handshake_done", {31'd0, done}, 32'd1);
  endtask

  task automatic reset_mid();
    exp_t e;
    e.addr = 32'h3000_0040; e.wdata = 32'h0; e.wstrb = 4'd0; e.sel = 1;
    e.issue = cyc; e.nvalid = 0; e.lat_cyc = 0; e.err = 1'b0; e.chk_rdata = 1'b0;
    e.rdata = '0; e.flag = 1'b0; e.eaddr = '0;
    exp_q.push_back(e);
    cur_lat = 100;
    mem_valid = 1'b1; mem_addr = e.addr; mem_wdata = 32'h0; mem_wstrb = 4'd0;
    repeat (3) @(negedge clk);
    check("pre_reset_s_valid", 32'(s_valid), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("reset_s_valid_async", 32'(s_valid), 32'd0);
    check("reset_no_ready", 32'(mem_ready), 32'd0);
    mem_valid = 1'b0;
    exp_q.delete();
    sv_cnt = 0;
    m_flag = 1'b0;
    m_eaddr = '0;
    repeat (2) begin
      @(negedge clk);
      check("reset_hold_ready", 32'(mem_ready), 32'd0);
    end
    check("reset_err_flag", 32'(err_flag), 32'd0);
    reset = 1'b0;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rbase [5];
    logic [31:0] a;
    logic [3:0]  ws;
    int          cls;
    int          lat;
    bit          clr;
    rbase = '{32'h0000_0000, 32'h3000_0000, 32'h0000_8000, 32'h2000_0000, 32'hF000_0000};
    reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0; err_clear = 1'b0;
    smem[{32'd0, 32'h100}] = 32'hCAFE_F00D;
    rmem[{32'd0, 32'h100}] = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_s_wdata", s_wdata, 32'd0);
    check("rst_s_wstrb", 32'(s_wstrb), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    reset = 1'b0;
    idle(1);

    issue(32'h0000_0100, 32'h0, 4'd0, 1, 1'b0);
    idle(1); issue(32'h3000_0010, 32'h1234_5678, 4'b0011, 0, 1'b0);
    idle(1); issue(32'h3000_0010, 32'h0, 4'd0, 2, 1'b0);
    idle(1); issue(32'hF000_0000, 32'h0, 4'd0, 0, 1'b0);
    idle(1); issue(32'h2000_0400, 32'h0, 4'd0, 100, 1'b0);
    idle(1); issue(32'h2000_0400, 32'h0, 4'd0, TO - 1, 1'b0);
    issue(32'h0000_9000, 32'h0, 4'd0, 0, 1'b0);
    issue(32'h0000_0200, 32'hA5A5_A5A5, 4'b1111, 3, 1'b0);
    idle(1); issue(32'hE000_0000, 32'h0, 4'd0, 0, 1'b1);
    idle(1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    m_flag = 1'b0;
    m_eaddr = '0;
    check("clear_err_flag", 32'(err_flag), 32'd0);
    check("clear_err_addr", err_addr, 32'd0);
    idle(1);
    reset_mid();
    issue(32'h0000_0100, 32'h0, 4'd0, 1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      cls = $urandom_range(0, 4);
      a = rbase[cls] + 32'(4 * $urandom_range(0, 7));
      lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 4) : $urandom_range(0, 3);
      ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      clr = !in_done && ($urandom_range(0, 5) == 0);
      issue(a, $urandom, ws, lat, clr);
    end

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
